// File: rtl/apb_pkg.sv
// Shared types and constants for the APB request master slice.
package apb_pkg;

  localparam int APB_ADDR_W = 18;
  localparam int APB_DATA_W = 32;

  // Read data reported for a transfer abandoned by the timeout counter.
  localparam logic [APB_DATA_W-1:0] APB_ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_req_master_if.sv
// Command, response and APB bus signals for apb_req_master.
// The master modport is the initiator's view; slave is the view of whatever
// drives commands, consumes responses and answers APB transfers.
interface apb_req_master_if;
  import apb_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [APB_ADDR_W-1:0] cmd_addr;
  logic [APB_DATA_W-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL;
  logic [APB_ADDR_W-1:0] PADDR;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PADDR, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PADDR, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting for PREADY and flags the cycle in which
// the wait reaches the limit. Only built when APB_REQ_TIMEOUT_EN is defined.
module apb_timeout_cnt (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_q;

  // Wait-cycle counter: cleared before each ACCESS phase, bumped per stalled cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 8'd1;
    end
  end

  // count_q holds the stalls before this cycle, so this stall is number count_q+1.
  assign expired = enable && (count_q == limit - 8'd1);

endmodule

// File: rtl/apb_req_master.sv
// APB initiator: turns valid/ready commands into APB SETUP/ACCESS transfers
// and returns the result on a valid/ready response channel.
// Optional feature macro: APB_REQ_TIMEOUT_EN (abort ACCESS after
// TIMEOUT_CYCLES stalled cycles, reporting rsp_err and ERR_RDATA).
module apb_req_master
  import apb_pkg::*;
#(
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [APB_DATA_W-1:0] ERR_RDATA      = APB_ERR_RDATA
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_req_master_if.master   bus
);

  apb_state_e            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timeout_hit;

`ifdef APB_REQ_TIMEOUT_EN
  apb_timeout_cnt u_timeout (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !bus.PREADY),
    .limit   (8'(TIMEOUT_CYCLES)),
    .expired (timeout_hit)
  );
`else
  // No counter in this build: ACCESS waits for PREADY indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State and every bus/response output are flops; nothing from cmd_* reaches APB combinationally.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and next-output decode; everything holds unless a transition changes it.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A PREADY arriving in the limit cycle still completes normally.
        if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ERR_RDATA;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One outstanding transaction: commands are only taken while idle.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: write/read timing, wait states,
// response backpressure, timeout (when APB_REQ_TIMEOUT_EN is defined),
// asynchronous reset mid-transfer and a small register loopback.
module tb_apb_req_master;
  import apb_pkg::*;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;

  always #5 PCLK = ~PCLK;

  apb_req_master_if bus ();

  apb_req_master #(
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (32'hDEADBEEF)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Peripheral side: manual PREADY/PRDATA, or a tiny register model
  // (WDEN at word 0x5, everything else reads 0xDEADBEEF, zero wait states).
  logic        auto_mode  = 1'b0;
  logic        man_pready = 1'b0;
  logic [31:0] man_prdata = '0;
  logic [31:0] wden_q     = '0;

  assign bus.PREADY = auto_mode ? 1'b1 : man_pready;
  assign bus.PRDATA = auto_mode ? ((bus.PADDR == 18'h5) ? wden_q : 32'hDEADBEEF) : man_prdata;

  // Register model write port.
  always_ff @(posedge PCLK) begin
    if (auto_mode && bus.PSEL && bus.PENABLE && bus.PWRITE && (bus.PADDR == 18'h5))
      wden_q <= {31'b0, bus.PWDATA[0]};
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Full transfer from IDLE; waits a bounded number of cycles for the response.
  task automatic xfer(input logic w, input logic [17:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    bit got;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    tick();
    bus.cmd_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk1("xfer_rsp_seen", got, 1'b1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    #1 PRESETn = 1'b0;
    tick();
    tick();
    chk1("rst_psel", bus.PSEL, 1'b0);
    chk1("rst_penable", bus.PENABLE, 1'b0);
    chk1("rst_pwrite", bus.PWRITE, 1'b0);
    chk("rst_paddr", 32'(bus.PADDR), 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    PRESETn = 1'b1;
    tick();

    // Write, zero wait states; PRDATA garbage must not leak into rsp_rdata
    man_pready = 1'b1;
    man_prdata = 32'hFFFF_FFFF;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 18'h1;
    bus.cmd_wdata = 32'hA5A5_0001;
    tick();
    bus.cmd_valid = 1'b0;
    chk1("wr_setup_psel", bus.PSEL, 1'b1);
    chk1("wr_setup_penable", bus.PENABLE, 1'b0);
    chk1("wr_setup_pwrite", bus.PWRITE, 1'b1);
    chk("wr_setup_paddr", 32'(bus.PADDR), 32'h1);
    chk("wr_setup_pwdata", bus.PWDATA, 32'hA5A5_0001);
    chk1("wr_setup_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    chk1("wr_access_psel", bus.PSEL, 1'b1);
    chk1("wr_access_penable", bus.PENABLE, 1'b1);
    chk1("wr_access_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk1("wr_resp_psel", bus.PSEL, 1'b0);
    chk1("wr_resp_penable", bus.PENABLE, 1'b0);
    chk1("wr_resp_valid", bus.rsp_valid, 1'b1);
    chk("wr_resp_rdata", bus.rsp_rdata, 32'h0);
    chk1("wr_resp_err", bus.rsp_err, 1'b0);
    chk1("wr_resp_cmd_ready", bus.cmd_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk1("wr_done_valid", bus.rsp_valid, 1'b0);
    chk1("wr_done_cmd_ready", bus.cmd_ready, 1'b1);

    // Read with 3 wait states
    man_pready = 1'b0;
    man_prdata = 32'h1234_5678;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 18'h0;
    bus.cmd_wdata = 32'h5555_5555;
    tick();
    bus.cmd_valid = 1'b0;
    chk1("rd_setup_psel", bus.PSEL, 1'b1);
    chk1("rd_setup_pwrite", bus.PWRITE, 1'b0);
    chk("rd_setup_paddr", 32'(bus.PADDR), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) man_pready = 1'b1;
      chk1("rd_access_psel", bus.PSEL, 1'b1);
      chk1("rd_access_penable", bus.PENABLE, 1'b1);
      chk("rd_access_paddr", 32'(bus.PADDR), 32'h0);
      chk1("rd_access_rsp_valid", bus.rsp_valid, 1'b0);
    end
    tick();
    chk1("rd_resp_valid", bus.rsp_valid, 1'b1);
    chk("rd_resp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk1("rd_resp_err", bus.rsp_err, 1'b0);
    chk1("rd_resp_psel", bus.PSEL, 1'b0);

    // Backpressure: response held 10 cycles while a second command waits
    man_pready = 1'b0;
    man_prdata = 32'h0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 18'h3;
    bus.cmd_wdata = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("bp_cmd_ready", bus.cmd_ready, 1'b0);
      chk1("bp_psel", bus.PSEL, 1'b0);
      chk1("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk1("bp_hs_valid", bus.rsp_valid, 1'b0);
    chk1("bp_hs_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("bp_hs_psel", bus.PSEL, 1'b0);
    tick();
    bus.cmd_valid = 1'b0;
    chk1("bp2_setup_psel", bus.PSEL, 1'b1);
    chk("bp2_setup_paddr", 32'(bus.PADDR), 32'h3);
    chk("bp2_setup_pwdata", bus.PWDATA, 32'h0BAD_F00D);
    man_pready = 1'b1;
    tick();
    tick();
    chk1("bp2_resp_valid", bus.rsp_valid, 1'b1);
    chk("bp2_resp_rdata", bus.rsp_rdata, 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Long PREADY stall: aborts after 4 ACCESS cycles only with the timeout build
    man_pready = 1'b0;
    man_prdata = 32'h7777_7777;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 18'h9;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("to_access_penable", bus.PENABLE, 1'b1);
      chk1("to_access_rsp_valid", bus.rsp_valid, 1'b0);
    end
    tick();
`ifdef APB_REQ_TIMEOUT_EN
    chk1("to_abort_psel", bus.PSEL, 1'b0);
    chk1("to_abort_penable", bus.PENABLE, 1'b0);
    chk1("to_abort_valid", bus.rsp_valid, 1'b1);
    chk1("to_abort_err", bus.rsp_err, 1'b1);
    chk("to_abort_rdata", bus.rsp_rdata, 32'hDEADBEEF);
`else
    for (int i = 0; i < 6; i++) begin
      chk1("nto_wait_penable", bus.PENABLE, 1'b1);
      chk1("nto_wait_rsp_valid", bus.rsp_valid, 1'b0);
      tick();
    end
    man_pready = 1'b1;
    tick();
    chk1("nto_done_valid", bus.rsp_valid, 1'b1);
    chk1("nto_done_err", bus.rsp_err, 1'b0);
    chk("nto_done_rdata", bus.rsp_rdata, 32'h7777_7777);
`endif
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk1("to_back_idle", bus.cmd_ready, 1'b1);

    // Asynchronous reset while PENABLE is high
    man_pready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 18'h7;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk1("mr_penable_before", bus.PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk1("mr_psel", bus.PSEL, 1'b0);
    chk1("mr_penable", bus.PENABLE, 1'b0);
    chk1("mr_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mr_paddr", 32'(bus.PADDR), 32'h0);
    chk1("mr_cmd_ready", bus.cmd_ready, 1'b1);
    PRESETn = 1'b1;
    tick();
    man_pready = 1'b1;
    man_prdata = 32'hCAFE_0007;
    xfer(1'b0, 18'h7, 32'h0, rd, er);
    chk("mr_after_rdata", rd, 32'hCAFE_0007);
    chk1("mr_after_err", er, 1'b0);

    // Loopback against the register model
    auto_mode = 1'b1;
    xfer(1'b1, 18'h5, 32'h0000_0001, rd, er);
    chk("lb_wr_rdata", rd, 32'h0);
    xfer(1'b0, 18'h5, 32'h0, rd, er);
    chk("lb_rd_wden", rd, 32'h0000_0001);
    chk1("lb_rd_wden_err", er, 1'b0);
    xfer(1'b0, 18'h2, 32'h0, rd, er);
    chk("lb_rd_unmapped", rd, 32'hDEADBEEF);
    chk1("lb_rd_unmapped_err", er, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
